// File: rtl/acc_ctrl.sv
// -----------------------------------------------------------------------------
// acc_ctrl
//
// Accumulator controller for a 32-bit registered ALU. One instruction at a
// time is accepted over a valid/ready handshake, its operands and select are
// registered toward the ALU, and after the ALU's registered latency the ALU
// result and carry-out are captured into the accumulator and carry flag.
// A one-cycle done pulse follows every capture.
//
// Parameters
//   LAT              ALU result latency in clock edges (legal 1..7)
//
// Ports
//   clk              clock, all state changes on rising edge
//   rst              asynchronous reset, active-high
//   instr_valid      instruction present
//   instr_ready      block can accept an instruction (IDLE and not in reset)
//   instr_op[1:0]    0 CLR, 1 ADD, 2 NOT, 3 AND
//   instr_data[31:0] operand for ADD/AND
//   instr_use_carry  ADD only: feed the carry flag into alu_cin
//   aluSelect[1:0]   registered select to the ALU
//   alu_acc[31:0]    accumulator register, wired to ALU acc
//   alu_din[31:0]    operand register, wired to ALU din
//   alu_cin          registered carry-in to the ALU
//   alu_out[31:0]    ALU result
//   c_out            ALU carry-out
//   carry_q          carry flag
//   done             one-cycle pulse after the accumulator has been updated
// -----------------------------------------------------------------------------
module acc_ctrl #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [1:0]  instr_op,
  input  logic [31:0] instr_data,
  input  logic        instr_use_carry,
  output logic [1:0]  aluSelect,
  output logic [31:0] alu_acc,
  output logic [31:0] alu_din,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic        c_out,
  output logic        carry_q,
  output logic        done
);

  // Opcode encodings shared with the ALU select.
  localparam logic [1:0] OP_ADD = 2'd1;

  // Counter is loaded with LAT-1 so that EXEC lasts exactly LAT edges.
  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_s;
  logic       accept_s;
  logic       capt_s;

  // Ready is decoded from the state but forced low while reset is asserted,
  // so a source never sees a handshake that the held-in-reset flops ignore.
  assign instr_ready = (state_r == IDLE) && !rst;

  assign accept_s = instr_valid && (state_r == IDLE);
  assign capt_s   = (state_r == CAPT);

  // Next-state and latency-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
          cnt_s   = LAT_M1;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        // The ALU result is registered on the edge where the count hits 0;
        // the following edge is the capture edge.
        if (cnt_r == 3'd0) begin
          state_s = CAPT;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      CAPT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Operand registers: loaded only on acceptance and held until the next one,
  // so input changes during EXEC/CAPT never reach the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluSelect <= 2'd0;
      alu_din   <= 32'd0;
      alu_cin   <= 1'b0;
    end else if (accept_s) begin
      aluSelect <= instr_op;
      alu_din   <= instr_data;
      alu_cin   <= ((instr_op == OP_ADD) && instr_use_carry) ? carry_q : 1'b0;
    end else begin
      aluSelect <= aluSelect;
      alu_din   <= alu_din;
      alu_cin   <= alu_cin;
    end
  end

  // Accumulator and carry flag: updated only at the capture edge. Only ADD
  // produces a meaningful carry; every other op clears the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_acc <= 32'd0;
      carry_q <= 1'b0;
    end else if (capt_s) begin
      alu_acc <= alu_out;
      carry_q <= (aluSelect == OP_ADD) ? c_out : 1'b0;
    end else begin
      alu_acc <= alu_acc;
      carry_q <= carry_q;
    end
  end

  // Completion pulse for the cycle following the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= capt_s;
    end
  end

endmodule

// File: tb/tb_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acc_ctrl
//
// Directed bench for acc_ctrl. Two instances are built, one with LAT=1 and
// one with LAT=3, each driving a behavioral registered ALU (LAT-deep pipeline,
// 33-bit add). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_acc_ctrl;

  localparam logic [1:0] CLR = 2'd0;
  localparam logic [1:0] ADD = 2'd1;
  localparam logic [1:0] NOT = 2'd2;
  localparam logic [1:0] AND = 2'd3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // LAT=1 instance signals
  logic        v1, uc1, rdy1, cin1, cout1, cq1, done1;
  logic [1:0]  op1, sel1;
  logic [31:0] dat1, acc1, din1, aout1;

  // LAT=3 instance signals
  logic        v3, uc3, rdy3, cin3, cout3, cq3, done3;
  logic [1:0]  op3, sel3;
  logic [31:0] dat3, acc3, din3, aout3;

  acc_ctrl #(.LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .instr_valid(v1), .instr_ready(rdy1), .instr_op(op1), .instr_data(dat1),
    .instr_use_carry(uc1), .aluSelect(sel1), .alu_acc(acc1), .alu_din(din1),
    .alu_cin(cin1), .alu_out(aout1), .c_out(cout1), .carry_q(cq1), .done(done1)
  );

  acc_ctrl #(.LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .instr_valid(v3), .instr_ready(rdy3), .instr_op(op3), .instr_data(dat3),
    .instr_use_carry(uc3), .aluSelect(sel3), .alu_acc(acc3), .alu_din(din3),
    .alu_cin(cin3), .alu_out(aout3), .c_out(cout3), .carry_q(cq3), .done(done3)
  );

  // Behavioral ALU function: {carry, result}
  function automatic logic [32:0] alu_f(input logic [1:0] sel, input logic [31:0] a,
                                        input logic [31:0] d, input logic ci);
    case (sel)
      2'd0:    return 33'd0;
      2'd1:    return {1'b0, a} + {1'b0, d} + {32'd0, ci};
      2'd2:    return {1'b0, ~a};
      default: return {1'b0, a & d};
    endcase
  endfunction

  logic [32:0] p1_r;
  logic [32:0] p3_r [3];

  // Registered ALU models with LAT pipeline stages.
  always @(posedge clk) begin
    p1_r    <= alu_f(sel1, acc1, din1, cin1);
    p3_r[0] <= alu_f(sel3, acc3, din3, cin3);
    p3_r[1] <= p3_r[0];
    p3_r[2] <= p3_r[1];
  end

  assign aout1 = p1_r[31:0];
  assign cout1 = p1_r[32];
  assign aout3 = p3_r[2][31:0];
  assign cout3 = p3_r[2][32];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction to the LAT=1 instance and follow it to done.
  // Entered and left at #1 after a rising edge with the block idle.
  task automatic run1(input logic [1:0] op, input logic [31:0] d, input logic uc,
                      input logic exp_cin, input logic [31:0] exp_acc,
                      input logic exp_cq, input string tag);
    int n;
    chk({tag, ".ready"}, {31'd0, rdy1}, 32'd1);
    v1 = 1'b1; op1 = op; dat1 = d; uc1 = uc;
    @(posedge clk); #1;
    v1 = 1'b0; op1 = ~op; dat1 = ~d; uc1 = ~uc;
    chk({tag, ".din"}, din1, d);
    chk({tag, ".sel"}, {30'd0, sel1}, {30'd0, op});
    chk({tag, ".cin"}, {31'd0, cin1}, {31'd0, exp_cin});
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      chk({tag, ".busy"}, {31'd0, rdy1}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, 32'd2);
    chk({tag, ".acc"}, acc1, exp_acc);
    chk({tag, ".carry"}, {31'd0, cq1}, {31'd0, exp_cq});
    chk({tag, ".din_hold"}, din1, d);
  endtask

  function automatic logic [31:0] tab(input int k, input int s);
    if (k % s == 0) return 32'd1 << (k / s);
    else            return 32'h0000_1000 + 32'(k);
  endfunction

  task automatic setin(input int w, input logic v, input logic [31:0] d);
    if (w == 1) begin v1 = v; op1 = ADD; dat1 = d; uc1 = 1'b0; end
    else        begin v3 = v; op3 = ADD; dat3 = d; uc3 = 1'b0; end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 1) ? rdy1 : rdy3;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 1) ? done1 : done3;
  endfunction

  function automatic logic [31:0] get_din(input int w);
    return (w == 1) ? din1 : din3;
  endfunction

  function automatic logic [31:0] get_acc(input int w);
    return (w == 1) ? acc1 : acc3;
  endfunction

  // valid held high, data changing every cycle; accepts must be s edges apart
  // and only the values 1, 2, 4 (at the accepting cycles) may be taken.
  task automatic b2b(input int w, input int s, input string tag);
    int k, n, cnt;
    int edges [3];
    logic [31:0] last;
    k = 0; n = 0; last = 32'd0;
    edges[0] = 0; edges[1] = 0; edges[2] = 0;
    setin(w, 1'b1, tab(0, s));
    while (n < 3 && k < 40) begin
      if (get_rdy(w)) begin
        edges[n] = k;
        n++;
        last = tab(k, s);
      end
      @(posedge clk); #1;
      k++;
      if (n > 0) chk({tag, ".din"}, get_din(w), last);
      setin(w, (n < 3) ? 1'b1 : 1'b0, tab(k, s));
    end
    chk({tag, ".accepts"}, n, 32'd3);
    chk({tag, ".gap1"}, edges[1] - edges[0], s);
    chk({tag, ".gap2"}, edges[2] - edges[1], s);
    cnt = 0;
    while (get_done(w) !== 1'b1 && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".done"}, {31'd0, get_done(w)}, 32'd1);
    chk({tag, ".acc"}, get_acc(w), 32'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    v1 = 1'b0; op1 = CLR; dat1 = 32'd0; uc1 = 1'b0;
    v3 = 1'b0; op3 = CLR; dat3 = 32'd0; uc3 = 1'b0;

    // Reset state (checked after an edge with reset held)
    #12;
    chk("rst.ready", {31'd0, rdy1}, 32'd0);
    chk("rst.acc", acc1, 32'd0);
    chk("rst.din", din1, 32'd0);
    chk("rst.sel", {30'd0, sel1}, 32'd0);
    chk("rst.cin", {31'd0, cin1}, 32'd0);
    chk("rst.carry", {31'd0, cq1}, 32'd0);
    chk("rst.done", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel.ready", {31'd0, rdy1}, 32'd1);
    @(posedge clk); #1;

    // Basic ops
    run1(ADD, 32'd10,        1'b0, 1'b0, 32'd10,        1'b0, "add10");
    run1(NOT, 32'h1234_5678, 1'b0, 1'b0, 32'hFFFF_FFF5, 1'b0, "not");
    run1(CLR, 32'h5555_5555, 1'b0, 1'b0, 32'd0,         1'b0, "clr");
    run1(ADD, 32'hACA6_ADB6, 1'b0, 1'b0, 32'hACA6_ADB6, 1'b0, "add_aca6");
    run1(AND, 32'hACA6_ACA6, 1'b0, 1'b0, 32'hACA6_ACA6, 1'b0, "and_aca6");

    // Carry chain
    run1(CLR, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, "clr2");
    run1(NOT, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, "not_ones");
    run1(ADD, 32'd1,         1'b0, 1'b0, 32'd0,         1'b1, "add1_wrap");
    run1(ADD, 32'd0,         1'b1, 1'b1, 32'd1,         1'b0, "add_cin");
    run1(AND, 32'hF,         1'b0, 1'b0, 32'd1,         1'b0, "and_f");
    run1(ADD, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,         1'b1, "add_wrap2");
    // use_carry on a non-ADD op must not feed the carry; AND clears the flag
    run1(AND, 32'hF,         1'b1, 1'b0, 32'd0,         1'b0, "and_uc");
    // use_carry=0 on ADD with carry set ignores the flag
    run1(ADD, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, "add_max");
    run1(ADD, 32'd1,         1'b0, 1'b0, 32'd0,         1'b1, "add1_wrap2");
    run1(ADD, 32'd5,         1'b0, 1'b0, 32'd5,         1'b0, "add_nocin");

    // Back-to-back issue
    run1(CLR, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, "clr3");
    b2b(1, 3, "b2b_lat1");
    b2b(3, 5, "b2b_lat3");

    // Asynchronous reset during EXEC of ADD 5 from acc=7
    v1 = 1'b1; op1 = ADD; dat1 = 32'd5; uc1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("arst.exec_ready", {31'd0, rdy1}, 32'd0);
    chk("arst.exec_din", din1, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst.acc", acc1, 32'd0);
    chk("arst.din", din1, 32'd0);
    chk("arst.sel", {30'd0, sel1}, 32'd0);
    chk("arst.cin", {31'd0, cin1}, 32'd0);
    chk("arst.carry", {31'd0, cq1}, 32'd0);
    chk("arst.done", {31'd0, done1}, 32'd0);
    chk("arst.ready", {31'd0, rdy1}, 32'd0);
    chk("arst.acc3", acc3, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst.rel_ready", {31'd0, rdy1}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst.no_done", {31'd0, done1}, 32'd0);
      chk("arst.acc_zero", acc1, 32'd0);
    end

    // Normal operation resumes after reset
    run1(ADD, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0, "post_rst_add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_ctrl.md
# acc_ctrl

Accumulator controller that drives the 32-bit registered ALU. It accepts one instruction at a time over a valid/ready handshake and presents the operands and select to the ALU. After the ALU's registered latency it captures `alu_out`/`c_out` back into the accumulator and carry flag, then pulses `done`. The ALU consumes operands; this block sits at the other end of that interface and owns the accumulator state.

## Interface
- `LAT`, default 1: ALU result latency in clock edges; legal range 1..7.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: block can accept an instruction.
- `instr_op` in 2: 0 CLR, 1 ADD, 2 NOT, 3 AND.
- `instr_data` in 32: operand for ADD/AND; ignored for CLR/NOT.
- `instr_use_carry` in 1: ADD only; 1 drives `alu_cin` from the carry flag, 0 drives 0.
- `aluSelect` out 2: select to ALU.
- `alu_acc` out 32: accumulator register, wired to ALU `acc`.
- `alu_din` out 32: operand register, wired to ALU `din`.
- `alu_cin` out 1: carry-in to ALU.
- `alu_out` in 32: ALU result.
- `c_out` in 1: ALU carry-out.
- `carry_q` out 1: carry flag.
- `done` out 1: one-cycle pulse when the accumulator has been updated.

## Operation
- FSM states: IDLE, EXEC, CAPT.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready` at an edge:
  - register `aluSelect`<=`instr_op` and `alu_din`<=`instr_data`;
  - register `alu_cin`<=(`instr_op`==1 && `instr_use_carry`) ? `carry_q` : 0;
  - load the latency counter with `LAT`-1 and go to EXEC.
- EXEC: `instr_ready`=0. The counter decrements each edge. When it reaches 0, go to CAPT.
- CAPT: `instr_ready`=0. At the closing edge:
  - `alu_acc`<=`alu_out`;
  - `carry_q`<=(`aluSelect`==1) ? `c_out` : 0;
  - go to IDLE and assert `done` for the following cycle.
- `aluSelect`, `alu_din` and `alu_cin` hold their values from acceptance until the next accepted instruction.
- Inputs that change while not in IDLE are ignored.
- `alu_acc` changes only at the CAPT edge or on reset. The ALU recomputing every cycle is harmless because only the CAPT sample is used.
- Arithmetic is done entirely by the ALU. The block performs no width extension and keeps bit 32 of the sum only as `c_out`.

## Timing
- Reset values (asynchronous, while `rst`=1):
  - state=IDLE, `alu_acc`=0, `alu_din`=0, `alu_cin`=0, `aluSelect`=0, `carry_q`=0, `done`=0;
  - `instr_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- Accept edge T0. Operands are visible from T0. The ALU registers the result at T0+LAT, and the CAPT edge is T0+LAT+1.
- `done`=1 and `instr_ready`=1 during the cycle T0+LAT+1..T0+LAT+2. The earliest next accept is edge T0+LAT+2, so the issue period is LAT+2 cycles (3 for `LAT`=1).
- `done` and `instr_ready` may be high together. An instruction accepted in the `done` cycle is legal and uses the freshly updated `alu_acc`/`carry_q`.
- Reset mid-EXEC or mid-CAPT: the instruction is aborted, no `done` is produced, the accumulator is 0, and the block is back in IDLE.
- `instr_valid` high with `instr_ready`=0 is a no-op. The source must hold the instruction until it is accepted.

## Test plan
The bench uses a behavioral ALU: `LAT`-cycle registered output, 33-bit add with a correct `c_out`.
- Reset, then ADD `instr_data`=10, `use_carry`=0 -> `alu_acc`=10, `carry_q`=0; `done` goes high exactly 2 cycles after the accept edge; `instr_ready` stays low for those 2 cycles.
- From `alu_acc`=10, NOT -> `alu_acc`=0xFFFFFFF5, `carry_q`=0.
- CLR, then ADD 0xACA6ADB6, then AND 0xACA6ACA6 -> `alu_acc`=0xACA6ACA6.
- Carry chain:
  - from 0xFFFFFFFF, ADD 1 gives `alu_acc`=0 and `carry_q`=1;
  - then ADD 0 with `use_carry`=1 gives `alu_cin`=1 during EXEC and `alu_acc`=1;
  - then AND 0xF clears `carry_q` to 0.
- With `instr_valid` held high and data changed every cycle, three instructions are accepted exactly 3 edges apart (`LAT`=1). Mid-flight data changes do not alter `alu_din`. Repeat with `LAT`=3: 5-edge spacing.
- Assert `rst` asynchronously during EXEC of ADD 5 from `alu_acc`=7 -> all outputs go to 0 immediately, no `done` appears, and after release `instr_ready`=1 and `alu_acc`=0.
